// File: rtl/cache_ctrl.sv
// Sequencing controller for a direct-mapped, one-word-line, write-through /
// write-allocate cache. It takes one CPU request at a time and does the tag
// lookup. Misses and write-throughs go to memory over a valid/ack handshake
// that gives up after TIMEOUT request cycles.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | ready for a request; latches address/we/wdata on cpu_valid
// LOOKUP | tag compare; writes update the cache here (one cache_we)
// MEM_RD | read-miss fill request outstanding on the memory port
// FILL   | write fetched word into the cache, load it into cpu_rdata
// MEM_WR | write-through request outstanding on the memory port
// RESP   | one-cycle cpu_done; cpu_rdata/cpu_err are valid
module cache_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_valid,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ready,
  output logic                  cpu_done,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_err,
  input  logic                  hit,
  input  logic [DATA_WIDTH-1:0] cache_rdata,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic                  cache_we,
  output logic [DATA_WIDTH-1:0] cache_wdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  // Counter is never compared when TIMEOUT is 0, but keep it at least one bit wide.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // The cycle in which the count equals TIMEOUT-1 is the TIMEOUT-th request cycle.
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    MEM_RD = 3'd2,
    FILL   = 3'd3,
    MEM_WR = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] fill_q, fill_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  timeout_fire;

  assign timeout_fire = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  // State and datapath registers; reset returns everything to zero / IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      fill_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      fill_q  <= fill_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and register-update logic; ack beats a timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    fill_d  = fill_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (cpu_valid) begin
          addr_d  = cpu_addr;
          we_d    = cpu_we;
          wdata_d = cpu_wdata;
          err_d   = 1'b0;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        cnt_d = '0;
        if (we_q) begin
          state_d = MEM_WR;
        end else if (hit) begin
          rdata_d = cache_rdata;
          state_d = RESP;
        end else begin
          state_d = MEM_RD;
        end
      end
      MEM_RD: begin
        if (mem_ack) begin
          fill_d  = mem_rdata;
          state_d = FILL;
        end else if (timeout_fire) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FILL: begin
        rdata_d = fill_q;
        state_d = RESP;
      end
      MEM_WR: begin
        if (mem_ack) begin
          state_d = RESP;
        end else if (timeout_fire) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore outputs: decoded only from state and registers.
  always_comb begin
    cpu_ready   = (state_q == IDLE);
    cpu_done    = (state_q == RESP);
    cpu_rdata   = rdata_q;
    cpu_err     = err_q;
    cache_addr  = addr_q;
    cache_we    = ((state_q == LOOKUP) && we_q) || (state_q == FILL);
    cache_wdata = (state_q == FILL) ? fill_q : wdata_q;
    mem_req     = (state_q == MEM_RD) || (state_q == MEM_WR);
    mem_we      = (state_q == MEM_WR);
    mem_addr    = addr_q;
    mem_wdata   = wdata_q;
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: a small direct-mapped cache array and a memory
// responder surround the DUT; a transaction-level timing model predicts every
// output on every cycle, and directed cases pin the model with literal values.
module tb_cache_ctrl;
  localparam int T = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cpu_valid = 1'b0;
  logic       cpu_we = 1'b0;
  logic [7:0] cpu_addr = '0;
  logic [7:0] cpu_wdata = '0;
  logic       cpu_ready, cpu_done, cpu_err;
  logic [7:0] cpu_rdata;
  logic       hit;
  logic [7:0] cache_rdata, cache_addr, cache_wdata;
  logic       cache_we;
  logic       mem_req, mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_rdata = '0;

  cache_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .cpu_valid(cpu_valid), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .hit(hit), .cache_rdata(cache_rdata), .cache_addr(cache_addr), .cache_we(cache_we),
    .cache_wdata(cache_wdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- cache array (index = addr[3:0], tag = addr[7:4]) -------
  logic       cval [16] = '{default: 1'b0};
  logic [3:0] ctag [16] = '{default: 4'h0};
  logic [7:0] cdat [16] = '{default: 8'h00};
  logic       pre_en = 1'b0;
  logic [7:0] pre_addr = '0;
  logic [7:0] pre_data = '0;

  always @(posedge clk) begin
    if (cache_we) begin
      cval[cache_addr[3:0]] <= 1'b1;
      ctag[cache_addr[3:0]] <= cache_addr[7:4];
      cdat[cache_addr[3:0]] <= cache_wdata;
    end else if (pre_en) begin
      cval[pre_addr[3:0]] <= 1'b1;
      ctag[pre_addr[3:0]] <= pre_addr[7:4];
      cdat[pre_addr[3:0]] <= pre_data;
    end
  end

  assign hit = cval[cache_addr[3:0]] && (ctag[cache_addr[3:0]] == cache_addr[7:4]);
  assign cache_rdata = cdat[cache_addr[3:0]];

  // ---------------- request plan (driver-owned) ----------------------------
  logic       p_wr = 1'b0;
  logic [7:0] p_addr = '0, p_wdata = '0, p_data = '0;
  int         p_n = 0;

  // ---------------- reference model state (compare-process owned) ----------
  int         cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit         active = 0;
  int         t0 = 0, done_k = 0, cur_R = 0, cur_n = 0;
  logic       cur_wr = 0, cur_hit = 0, cur_err = 0;
  logic [7:0] cur_addr = 0, cur_wdata = 0, cur_data = 0, cur_hdata = 0;
  logic [7:0] exp_rdata = 0, exp_addr = 0;
  logic       exp_err = 0;
  int         acc_cnt = 0, closed_cnt = 0;
  int         obs_done_k = 0, obs_req = 0, obs_we = 0;
  logic [7:0] obs_rdata = 0;
  logic       obs_err = 0;

  // Memory responder: acks on the planned request cycle; stray acks while idle.
  int rc = 0;
  always @(negedge clk) begin
    if (!rst || !mem_req) begin
      rc = 0;
      mem_ack = rst && ($urandom_range(0, 7) == 0);
      mem_rdata = 8'($urandom);
    end else begin
      rc++;
      mem_ack = (rc == cur_n);
      mem_rdata = (rc == cur_n) ? cur_data : 8'($urandom);
    end
  end

  // Model + compare: expected outputs from the latency rules of each request.
  always @(negedge clk) begin
    int k;
    bit was_active;
    logic e_done, e_we, e_req;
    logic [7:0] e_wd;
    k = 0;
    if (!rst) begin
      if (active) closed_cnt++;
      active = 0;
      exp_rdata = 0;
      exp_err = 0;
      exp_addr = 0;
    end else if (active) begin
      k = cyc - t0;
      if (k == 1) begin
        exp_err = 0;
        exp_addr = cur_addr;
      end
      if (k == done_k) begin
        if (!cur_wr && !cur_err) exp_rdata = cur_hit ? cur_hdata : cur_data;
        exp_err = cur_err;
      end
    end
    was_active = active;
    e_done = 0; e_we = 0; e_req = 0; e_wd = 0;
    if (active) begin
      e_done = (k == done_k);
      e_req = (k >= 2) && (k <= cur_R + 1);
      if (cur_wr) begin
        e_we = (k == 1);
        e_wd = cur_wdata;
      end else if (!cur_hit && !cur_err) begin
        e_we = (k == cur_R + 2);
        e_wd = cur_data;
      end
    end
    chk("cpu_ready", cpu_ready, !active);
    chk("cpu_done", cpu_done, e_done);
    chk("cache_we", cache_we, e_we);
    chk("mem_req", mem_req, e_req);
    chk("cpu_rdata", cpu_rdata, exp_rdata);
    chk("cpu_err", cpu_err, exp_err);
    chk("cache_addr", cache_addr, exp_addr);
    if (e_we) chk("cache_wdata", cache_wdata, e_wd);
    if (e_req) begin
      chk("mem_we", mem_we, cur_wr);
      chk("mem_addr", mem_addr, cur_addr);
      if (cur_wr) chk("mem_wdata", mem_wdata, cur_wdata);
    end
    if (active) begin
      if (cpu_done && obs_done_k == 0) obs_done_k = k;
      obs_req += int'(mem_req);
      obs_we += int'(cache_we);
      if (k == done_k) begin
        active = 0;
        obs_rdata = cpu_rdata;
        obs_err = cpu_err;
        closed_cnt++;
      end
    end
    if (!was_active && rst && cpu_valid) begin
      active = 1;
      t0 = cyc;
      cur_wr = p_wr; cur_addr = p_addr; cur_wdata = p_wdata; cur_data = p_data; cur_n = p_n;
      cur_hit = cval[p_addr[3:0]] && (ctag[p_addr[3:0]] == p_addr[7:4]);
      cur_hdata = cdat[p_addr[3:0]];
      if (!p_wr && cur_hit) begin
        cur_R = 0; cur_err = 0; done_k = 2;
      end else begin
        if (p_n >= 1 && p_n <= T) begin
          cur_R = p_n; cur_err = 0;
        end else begin
          cur_R = T; cur_err = 1;
        end
        done_k = (p_wr || cur_err) ? cur_R + 2 : cur_R + 3;
      end
      obs_done_k = 0; obs_req = 0; obs_we = 0;
      acc_cnt++;
    end
  end

  // Present a request and hold cpu_valid until the accept edge has passed.
  task automatic issue(input logic wr, input logic [7:0] a, input logic [7:0] wd,
                       input int n, input logic [7:0] d);
    int a0, b;
    a0 = acc_cnt;
    p_wr = wr; p_addr = a; p_wdata = wd; p_n = n; p_data = d;
    cpu_we = wr; cpu_addr = a; cpu_wdata = wd; cpu_valid = 1'b1;
    b = 0;
    while (acc_cnt == a0 && b < 200) begin
      @(posedge clk);
      b++;
    end
    chk("accept_wait", acc_cnt != a0, 1'b1);
    #1;
  endtask

  task automatic wait_fin();
    int b;
    b = 0;
    while (closed_cnt != acc_cnt && b < 300) begin
      @(posedge clk);
      b++;
    end
    chk("finish_wait", closed_cnt == acc_cnt, 1'b1);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", cpu_ready, 1'b1);
    chk("rst_done", cpu_done, 1'b0);
    chk("rst_memreq", mem_req, 1'b0);
    chk("rst_rdata", cpu_rdata, 8'h00);
    pre_en = 1'b1; pre_addr = 8'h10; pre_data = 8'hA5;
    @(posedge clk); #1;
    pre_en = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

    // Read hit at 0x10.
    issue(1'b0, 8'h10, 8'h00, 0, 8'h00);
    cpu_valid = 1'b0;
    wait_fin();
    chk("hit_done_cycle", obs_done_k, 2);
    chk("hit_rdata", obs_rdata, 8'hA5);
    chk("hit_cache_we", obs_we, 0);
    chk("hit_mem_req", obs_req, 0);

    // Read miss 0x22, ack on third request cycle.
    issue(1'b0, 8'h22, 8'h00, 3, 8'h3C);
    cpu_valid = 1'b0;
    wait_fin();
    chk("miss_done_cycle", obs_done_k, 6);
    chk("miss_req_cycles", obs_req, 3);
    chk("miss_cache_we", obs_we, 1);
    chk("miss_rdata", obs_rdata, 8'h3C);
    chk("miss_err", obs_err, 1'b0);

    // Write 0x05 twice: first misses, second hits the allocated line.
    for (int i = 0; i < 2; i++) begin
      issue(1'b1, 8'h05, 8'h77, 1, 8'h00);
      cpu_valid = 1'b0;
      wait_fin();
      chk("wr_done_cycle", obs_done_k, 3);
      chk("wr_cache_we", obs_we, 1);
      chk("wr_req_cycles", obs_req, 1);
      chk("wr_rdata_kept", obs_rdata, 8'h3C);
    end

    // Read miss with no ack: timeout.
    issue(1'b0, 8'h33, 8'h00, 0, 8'h00);
    cpu_valid = 1'b0;
    wait_fin();
    chk("to_req_cycles", obs_req, 15);
    chk("to_done_cycle", obs_done_k, 17);
    chk("to_err", obs_err, 1'b1);
    chk("to_cache_we", obs_we, 0);
    chk("to_rdata_kept", obs_rdata, 8'h3C);

    // Ack coincident with the last allowed request cycle.
    issue(1'b0, 8'h44, 8'h00, 15, 8'h5A);
    cpu_valid = 1'b0;
    wait_fin();
    chk("edge_done_cycle", obs_done_k, 18);
    chk("edge_err", obs_err, 1'b0);
    chk("edge_rdata", obs_rdata, 8'h5A);

    // Reset in the second MEM_RD cycle.
    issue(1'b0, 8'h66, 8'h00, 0, 8'h00);
    cpu_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("pre_rst_memreq", mem_req, 1'b1);
    rst = 1'b0;
    #1;
    chk("abort_memreq", mem_req, 1'b0);
    chk("abort_cache_we", cache_we, 1'b0);
    chk("abort_done", cpu_done, 1'b0);
    chk("abort_ready", cpu_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Write, then a read held pending while the write is busy.
    issue(1'b1, 8'h10, 8'hC3, 2, 8'h00);
    issue(1'b0, 8'h10, 8'h00, 0, 8'h00);
    cpu_valid = 1'b0;
    wait_fin();
    chk("held_read_done_cycle", obs_done_k, 2);
    chk("held_read_rdata", obs_rdata, 8'hC3);

    // Randomized traffic, with back-to-back requests and idle gaps.
    for (int i = 0; i < 300; i++) begin
      logic [7:0] a;
      int n, sel;
      a = {3'b000, 1'($urandom_range(0, 1)), 2'b00, 2'($urandom_range(0, 3))};
      sel = $urandom_range(0, 9);
      if (sel < 7) n = $urandom_range(1, 4);
      else if (sel == 7) n = 15;
      else if (sel == 8) n = $urandom_range(14, 16);
      else n = 0;
      issue(1'($urandom_range(0, 1)), a, 8'($urandom), n, 8'($urandom));
      if ($urandom_range(0, 1) == 0) begin
        cpu_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end
    cpu_valid = 1'b0;
    wait_fin();
    repeat (3) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Sequencing controller for the direct-mapped, one-word-line, write-through / write-allocate cache and its backing memory.
- Accepts one CPU request at a time and performs the tag lookup.
- Issues memory read-fill or write-through transactions over a valid/ack handshake with a timeout.
- Generates exactly one cache_we pulse per cache update and returns read data with a done pulse.

Parameters:
ADDR_WIDTH, 8, width of CPU, cache and memory addresses
DATA_WIDTH, 8, width of data words
TIMEOUT, 15, max consecutive mem_req cycles without mem_ack before error; 0 disables timeout

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
cpu_valid  in  1  CPU request present
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_WIDTH  request address
cpu_wdata  in  DATA_WIDTH  write data
cpu_ready  out  1  controller idle, request accepted this cycle if cpu_valid
cpu_done  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_WIDTH  read data, valid with cpu_done on reads
cpu_err  out  1  memory timeout flag, valid with cpu_done
hit  in  1  combinational tag-match for cache_addr
cache_rdata  in  DATA_WIDTH  combinational cache data for cache_addr
cache_addr  out  ADDR_WIDTH  lookup/write address (latched request address)
cache_we  out  1  cache write strobe
cache_wdata  out  DATA_WIDTH  cache write data
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1=memory write, valid while mem_req
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_ack  in  1  memory completion, one cycle
mem_rdata  in  DATA_WIDTH  read data, valid with mem_ack

Behaviour:
- Reset (rst=0, async): state IDLE, all registers 0.
  - Outputs during reset: cpu_ready=1; cpu_done, cpu_err, cache_we, mem_req, mem_we = 0; cpu_rdata and latched address/data = 0.
  - Reset mid-transaction aborts immediately: mem_req drops, no cache_we, no cpu_done.
- Moore FSM states: IDLE, LOOKUP, MEM_RD, FILL, MEM_WR, RESP.
- All outputs decode from state plus registers; none come combinationally from inputs.
- IDLE:
  - cpu_ready=1.
  - On cpu_valid, latch cpu_addr, cpu_we, cpu_wdata and go to LOOKUP.
  - cpu_valid while not IDLE is ignored; no queuing.
- LOOKUP:
  - cache_addr = latched address; hit is sampled this cycle.
  - Read hit: cpu_rdata <= cache_rdata, go to RESP.
  - Read miss: go to MEM_RD.
  - Write, hit or miss: cache_we=1 for this cycle only, cache_wdata = latched wdata, go to MEM_WR.
- MEM_RD: mem_req=1, mem_we=0, mem_addr = latched address, held stable.
  - On mem_ack: capture mem_rdata into fill register, go to FILL.
- FILL:
  - cache_we=1 for one cycle, cache_wdata = fill data.
  - cpu_rdata <= fill data, go to RESP.
- MEM_WR: mem_req=1, mem_we=1, mem_addr and mem_wdata = latched values.
  - On mem_ack, go to RESP.
- RESP: cpu_done=1 for one cycle, then go to IDLE.
  - cpu_rdata holds until the next read completes.
  - cpu_err stays valid until the next acceptance, where it clears.
- Timeout:
  - Counter of width $clog2(TIMEOUT+1), cleared on entering MEM_RD/MEM_WR.
  - Increments each mem_req cycle without mem_ack.
  - When count reaches TIMEOUT without ack: set cpu_err=1, drop mem_req, go to RESP.
  - Read timeout skips FILL, so no cache write; cpu_rdata is unchanged.
  - Write timeout: the cache was already written in LOOKUP (accepted inconsistency, flagged by cpu_err).
- mem_ack in the same cycle the timeout would fire: ack wins, no error.
- mem_ack outside MEM_RD/MEM_WR is ignored.
- cache_we rules:
  - Never asserted in consecutive cycles.
  - Exactly one pulse per write request and per completed read miss.
  - Zero pulses for read hits and read timeouts.
- Latency, with accept edge = cycle 0:
  - Read hit: done in cycle 2.
  - Read miss with ack in the Nth MEM_RD cycle: done in cycle N+3.
  - Write with ack in the Nth MEM_WR cycle: done in cycle N+2.
- Back-to-back: cpu_ready returns the cycle after RESP; minimum request spacing is 3 cycles.

Test Plan:
- Reset, then read addr 0x10 with hit=1, cache_rdata=0xA5 -> cpu_done in cycle 2, cpu_rdata=0xA5, no cache_we, no mem_req.
- Read 0x22 with hit=0, mem_ack on 3rd MEM_RD cycle with mem_rdata=0x3C:
  - mem_req high for 3 cycles with mem_we=0 and mem_addr=0x22.
  - Single cache_we pulse with cache_wdata=0x3C.
  - cpu_done in cycle 6, cpu_rdata=0x3C, cpu_err=0.
- Write 0x05 with data 0x77, once with hit=1 and once with hit=0, mem_ack on 1st cycle:
  - Each produces one cache_we in cycle 1 with data 0x77.
  - mem_req/mem_we high in cycle 2, cpu_done in cycle 3.
- Read miss with mem_ack never asserted, TIMEOUT=15 -> mem_req high exactly 15 cycles, then cpu_done with cpu_err=1, no cache_we, cpu_rdata unchanged.
- mem_ack coincident with the 15th request cycle -> completes normally, cpu_err=0.
- Assert rst=0 in the 2nd MEM_RD cycle -> mem_req, cache_we, cpu_done all 0 immediately.
  - After release, a new read hit completes normally.
  - cpu_valid held high during a busy transaction is not accepted until cpu_ready.
